// File: rtl/rv_alu_pipe_pkg.sv
// Shared RISC-V ALU pipeline definitions: opcodes, funct codes, ALU op enum and
// field-slice helpers that do not depend on XLEN.
package rv_alu_pipe_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    function automatic logic [6:0] opcode_of(input logic [31:0] i);
        return i[6:0];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] i);
        return i[11:7];
    endfunction

    function automatic logic [2:0] funct3_of(input logic [31:0] i);
        return i[14:12];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [31:0] i);
        return i[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] i);
        return i[24:20];
    endfunction

    function automatic logic [6:0] funct7_of(input logic [31:0] i);
        return i[31:25];
    endfunction

    // alt is instr[30]: selects sub over add and arithmetic over logical right shift
    function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_alu_pipe_alu.sv
// Combinational integer ALU for the rv_alu_pipe execute stage.
module rv_alu_pipe_alu
    import rv_alu_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         alu_op,
    output logic [XLEN-1:0] y
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt_s;

    assign shamt_s = b[SHW-1:0];

    // Result select; compares produce a zero-extended 0/1
    always_comb begin
        y = {XLEN{1'b0}};
        case (alu_op)
            ALU_ADD:    y = a + b;
            ALU_SUB:    y = a - b;
            ALU_SLL:    y = a << shamt_s;
            ALU_SLT:    y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:   y = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:    y = a ^ b;
            ALU_SRL:    y = a >> shamt_s;
            ALU_SRA:    y = $signed(a) >>> shamt_s;
            ALU_OR:     y = a | b;
            ALU_AND:    y = a & b;
            ALU_PASS_B: y = b;
            default:    y = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/rv_alu_pipe.sv
// 3-stage (D/E/W) RV32I/RV64I ALU pipeline with regfile, illegal-op counter and debug port.
// Define RV_FWD_EN to enable W->E operand forwarding.
module rv_alu_pipe
    import rv_alu_pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [31:0]     in,
    output logic [XLEN-1:0] alu_output_data,
    output logic            out_valid,
    output logic [4:0]      out_rd,
    output logic            illegal,
    output logic [7:0]      illegal_cnt,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam int         RI     = $clog2(NREG);
    localparam logic [5:0] NREG_W = 6'(NREG);

    logic            d_valid_r;
    logic [31:0]     d_instr_r;
    logic            w_valid_r;
    logic            w_illegal_r;
    logic [4:0]      w_rd_r;
    logic [XLEN-1:0] w_data_r;
    logic [7:0]      cnt_r;
    logic [XLEN-1:0] rf_r [NREG];

    logic [6:0]      opcode_s, f7_s, shift_hi_s;
    logic [2:0]      f3_s;
    logic [4:0]      rd_s, rs1_s, rs2_s;
    alu_op_t         alu_op_s;
    logic            use_imm_s, rs1_used_s, rs2_used_s, bad_op_s, bad_reg_s;
    logic            fwd1_s, fwd2_s, e_valid_s, e_illegal_s;
    logic [XLEN-1:0] imm_s, rs1_val_s, rs2_val_s, op_a_s, op_b_s, alu_y_s;

    assign opcode_s = opcode_of(d_instr_r);
    assign f3_s     = funct3_of(d_instr_r);
    assign f7_s     = funct7_of(d_instr_r);
    assign rd_s     = rd_of(d_instr_r);
    assign rs1_s    = rs1_of(d_instr_r);
    assign rs2_s    = rs2_of(d_instr_r);
    // RV64 shifts use instr[25] as shamt[5], so only [31:26] carry the funct code
    assign shift_hi_s = (XLEN == 64) ? {d_instr_r[31:26], 1'b0} : d_instr_r[31:25];
    assign imm_s = (opcode_s == OPC_LUI) ? XLEN'($signed({d_instr_r[31:12], 12'h000}))
                                         : XLEN'($signed(d_instr_r[31:20]));

    // Decode: ALU op, operand usage and unsupported encodings
    always_comb begin
        alu_op_s   = ALU_ADD;
        use_imm_s  = 1'b0;
        rs1_used_s = 1'b0;
        rs2_used_s = 1'b0;
        bad_op_s   = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b1;
                if (f7_s == F7_BASE) begin
                    alu_op_s = alu_op_from_f3(f3_s, 1'b0);
                end else if (f7_s == F7_ALT && (f3_s == F3_ADD || f3_s == F3_SR)) begin
                    alu_op_s = alu_op_from_f3(f3_s, 1'b1);
                end else begin
                    bad_op_s = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                rs1_used_s = 1'b1;
                use_imm_s  = 1'b1;
                if (f3_s == F3_SLL) begin
                    if (shift_hi_s == F7_BASE) alu_op_s = ALU_SLL;
                    else bad_op_s = 1'b1;
                end else if (f3_s == F3_SR) begin
                    if (shift_hi_s == F7_BASE) alu_op_s = ALU_SRL;
                    else if (shift_hi_s == F7_ALT) alu_op_s = ALU_SRA;
                    else bad_op_s = 1'b1;
                end else begin
                    alu_op_s = alu_op_from_f3(f3_s, 1'b0);
                end
            end
            OPC_LUI: begin
                use_imm_s = 1'b1;
                alu_op_s  = ALU_PASS_B;
            end
            default: bad_op_s = 1'b1;
        endcase
    end

    assign bad_reg_s = ({1'b0, rd_s} >= NREG_W)
                    || (rs1_used_s && ({1'b0, rs1_s} >= NREG_W))
                    || (rs2_used_s && ({1'b0, rs2_s} >= NREG_W));

    // Register file read ports; out-of-range indices read as zero
    always_comb begin
        rs1_val_s = {XLEN{1'b0}};
        rs2_val_s = {XLEN{1'b0}};
        if ({1'b0, rs1_s} < NREG_W) rs1_val_s = rf_r[rs1_s[RI-1:0]];
        else rs1_val_s = {XLEN{1'b0}};
        if ({1'b0, rs2_s} < NREG_W) rs2_val_s = rf_r[rs2_s[RI-1:0]];
        else rs2_val_s = {XLEN{1'b0}};
    end

`ifdef RV_FWD_EN
    assign fwd1_s = w_valid_r && (w_rd_r != 5'd0) && (w_rd_r == rs1_s);
    assign fwd2_s = w_valid_r && (w_rd_r != 5'd0) && (w_rd_r == rs2_s);
`else
    assign fwd1_s = 1'b0;
    assign fwd2_s = 1'b0;
`endif

    assign op_a_s = fwd1_s ? w_data_r : rs1_val_s;
    assign op_b_s = use_imm_s ? imm_s : (fwd2_s ? w_data_r : rs2_val_s);

    rv_alu_pipe_alu #(.XLEN(XLEN)) u_alu (
        .a      (op_a_s),
        .b      (op_b_s),
        .alu_op (alu_op_s),
        .y      (alu_y_s)
    );

    assign e_valid_s   = d_valid_r && !bad_op_s && !bad_reg_s;
    assign e_illegal_s = d_valid_r && (bad_op_s || bad_reg_s);

    // D stage capture; an all-zero word is dropped as a silent NOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid_r <= 1'b0;
            d_instr_r <= 32'h0;
        end else begin
            d_valid_r <= in_valid && (in != 32'h0);
            d_instr_r <= in_valid ? in : 32'h0;
        end
    end

    // W stage result registers and saturating illegal counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_valid_r   <= 1'b0;
            w_illegal_r <= 1'b0;
            w_rd_r      <= 5'd0;
            w_data_r    <= {XLEN{1'b0}};
            cnt_r       <= 8'd0;
        end else begin
            w_valid_r   <= e_valid_s;
            w_illegal_r <= e_illegal_s;
            w_rd_r      <= e_valid_s ? rd_s : 5'd0;
            w_data_r    <= e_valid_s ? alu_y_s : {XLEN{1'b0}};
            if (e_illegal_s && cnt_r != 8'hFF) cnt_r <= cnt_r + 8'd1;
        end
    end

    // Regfile write-back from W; x0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_r[i] <= {XLEN{1'b0}};
        end else if (w_valid_r && w_rd_r != 5'd0) begin
            rf_r[w_rd_r[RI-1:0]] <= w_data_r;
        end
    end

    assign alu_output_data = w_data_r;
    assign out_valid       = w_valid_r;
    assign out_rd          = w_rd_r;
    assign illegal         = w_illegal_r;
    assign illegal_cnt     = cnt_r;
    assign dbg_data = (dbg_addr != 5'd0 && {1'b0, dbg_addr} < NREG_W) ? rf_r[dbg_addr[RI-1:0]]
                                                                      : {XLEN{1'b0}};

endmodule

// File: tb/tb_rv_alu_pipe.sv
// Directed self-checking bench for rv_alu_pipe (XLEN=32, NREG=32) with an
// architectural model and per-cycle output comparison.
module tb_rv_alu_pipe;

    localparam int XLEN = 32;

    logic            clk, rst_n, in_valid, out_valid, illegal;
    logic [31:0]     in;
    logic [XLEN-1:0] alu_output_data, dbg_data;
    logic [4:0]      out_rd, dbg_addr;
    logic [7:0]      illegal_cnt;

    rv_alu_pipe #(.XLEN(XLEN), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
        .alu_output_data(alu_output_data), .out_valid(out_valid), .out_rd(out_rd),
        .illegal(illegal), .illegal_cnt(illegal_cnt),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        valid;
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        expq [0:1023];
    exp_t        last;
    logic [31:0] arch [32];
    logic [31:0] lag  [32];
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    int          mcnt  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'h37};
    endfunction

    // Operand as seen by an instruction: without forwarding, the immediately
    // preceding slot's write is not yet visible.
    function automatic logic [31:0] src(input logic [4:0] r);
`ifdef RV_FWD_EN
        return arch[r];
`else
        return lag[r];
`endif
    endfunction

    task automatic exec(input logic [31:0] ins, output exp_t e);
        logic [31:0] a, b, imm, r;
        logic        ok;
        ok = 1'b1;
        r = 32'h0;
        a = src(ins[19:15]);
        b = src(ins[24:20]);
        imm = {{20{ins[31]}}, ins[31:20]};
        case (ins[6:0])
            7'h33: case ({ins[31:25], ins[14:12]})
                10'h000: r = a + b;
                10'h100: r = a - b;
                10'h001: r = a << b[4:0];
                10'h002: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                10'h003: r = (a < b) ? 32'd1 : 32'd0;
                10'h004: r = a ^ b;
                10'h005: r = a >> b[4:0];
                10'h105: r = $signed(a) >>> b[4:0];
                10'h006: r = a | b;
                10'h007: r = a & b;
                default: ok = 1'b0;
            endcase
            7'h13: case (ins[14:12])
                3'd0: r = a + imm;
                3'd2: r = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                3'd3: r = (a < imm) ? 32'd1 : 32'd0;
                3'd4: r = a ^ imm;
                3'd6: r = a | imm;
                3'd7: r = a & imm;
                3'd1: if (ins[31:25] == 7'h00) r = a << ins[24:20]; else ok = 1'b0;
                default: if (ins[31:25] == 7'h00) r = a >> ins[24:20];
                         else if (ins[31:25] == 7'h20) r = $signed(a) >>> ins[24:20];
                         else ok = 1'b0;
            endcase
            7'h37: r = {ins[31:12], 12'h000};
            default: ok = 1'b0;
        endcase
        e.valid = ok;
        e.ill   = !ok;
        e.rd    = ok ? ins[11:7] : 5'd0;
        e.data  = ok ? r : 32'h0;
    endtask

    task automatic step(input logic v, input logic [31:0] ins);
        @(negedge clk);
        in_valid = v;
        in = ins;
        last = '0;
        if (v && ins != 32'h0) exec(ins, last);
        expq[cyc + 2] = last;
        lag = arch;
        if (last.valid && last.rd != 5'd0) arch[last.rd] = last.data;
    endtask

    task automatic go(input logic [31:0] ins);
        step(1'b1, ins);
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, 32'h0);
    endtask

    task automatic dbg(input logic [4:0] a, input logic [31:0] want, input string nm);
        dbg_addr = a;
        #1;
        chk(nm, dbg_data, want);
    endtask

    // Single compare process: checks every output, every cycle, against the model
    initial begin : compare
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (!rst_n) mcnt = 0;
            else if (expq[cyc].ill && mcnt < 255) mcnt = mcnt + 1;
            chk("out_valid", out_valid, expq[cyc].valid);
            chk("illegal", illegal, expq[cyc].ill);
            chk("illegal_cnt", illegal_cnt, mcnt);
            if (expq[cyc].valid) begin
                chk("alu_output_data", alu_output_data, expq[cyc].data);
                chk("out_rd", out_rd, expq[cyc].rd);
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < 1024; i++) expq[i] = '0;
        for (int i = 0; i < 32; i++) begin
            arch[i] = 32'h0;
            lag[i]  = 32'h0;
        end
        rst_n = 1'b0; in_valid = 1'b0; in = 32'h0; dbg_addr = 5'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset data", alu_output_data, 32'h0);
        chk("reset illegal_cnt", illegal_cnt, 8'd0);
        rst_n = 1'b1;

        // addi x1..x31 = 1..31 back-to-back
        for (int i = 1; i < 32; i++) begin
            go(enc_i(3'd0, 5'(i), 5'd0, 12'(i)));
            chk("t1 model", last.data, 32'(i));
        end
        step(1'b0, enc_i(3'd0, 5'd2, 5'd0, 12'h7FF));
        step(1'b1, 32'h0);
        drain(3);
        dbg(5'd31, 32'd31, "dbg x31");
        dbg(5'd12, 32'd12, "dbg x12");
        dbg(5'd2, 32'd2, "dbg x2 after bubble");

        // rd = x0 still produces output; x0 never forwarded
        go(enc_r(7'h00, 3'd0, 5'd0, 5'd20, 5'd12));
        chk("t4 add x0 data", last.data, 32'd32);
        chk("t4 add x0 rd", last.rd, 5'd0);
        go(enc_r(7'h00, 3'd0, 5'd1, 5'd0, 5'd0));
        chk("t4 add x1,x0,x0", last.data, 32'd0);
        go(enc_i(3'd0, 5'd1, 5'd0, 12'd1));
        drain(3);
        dbg(5'd0, 32'd0, "dbg x0");

        // dependency chain
        go(enc_i(3'd0, 5'd5, 5'd0, 12'd36));
        drain(2);
        go(enc_i(3'd0, 5'd5, 5'd0, 12'd5));
        chk("t2 addi x5", last.data, 32'd5);
        go(enc_r(7'h00, 3'd0, 5'd6, 5'd5, 5'd1));
`ifdef RV_FWD_EN
        chk("t2 add x6", last.data, 32'd6);
`else
        chk("t2 add x6 stale", last.data, 32'd37);
`endif
        go(enc_i(3'd0, 5'd7, 5'd6, 12'd1));
        chk("t2 addi x7", last.data, 32'd7);
        go(enc_r(7'h20, 3'd0, 5'd8, 5'd15, 5'd7));
        chk("t2 sub x8", last.data, 32'd8);
        drain(3);

        // shifts and compares on a negative value
        go(enc_i(3'd0, 5'd10, 5'd0, 12'hF9C));
        drain(1);
        go(enc_i(3'd5, 5'd11, 5'd10, 12'h008));
        chk("t3 srli", last.data, 32'h00FFFFFF);
        go(enc_i(3'd5, 5'd12, 5'd10, 12'h408));
        chk("t3 srai", last.data, 32'hFFFFFFFF);
        go(enc_r(7'h20, 3'd5, 5'd14, 5'd10, 5'd4));
        chk("t3 sra", last.data, 32'hFFFFFFF9);
        go(enc_i(3'd3, 5'd11, 5'd20, 12'hFF8));
        chk("t3 sltiu", last.data, 32'd1);
        go(enc_r(7'h00, 3'd2, 5'd16, 5'd10, 5'd0));
        chk("slt neg", last.data, 32'd1);
        go(enc_r(7'h00, 3'd3, 5'd17, 5'd10, 5'd0));
        chk("sltu neg", last.data, 32'd0);
        go(enc_i(3'd4, 5'd18, 5'd10, 12'hFFF));
        chk("xori -1", last.data, 32'd99);
        go(enc_i(3'd1, 5'd19, 5'd4, 12'd28));
        chk("slli", last.data, 32'h40000000);
        go(enc_r(7'h01, 3'd0, 5'd3, 5'd1, 5'd2));
        chk("bad funct7 model", last.ill, 1'b1);
        go(enc_u(5'd15, 20'hFFFFF));
        chk("t5 lui", last.data, 32'hFFFFF000);
        drain(3);
        dbg(5'd15, 32'hFFFFF000, "dbg x15");

        // illegal flood saturates the counter
        repeat (300) go(32'h0000007F);
        drain(3);
        chk("illegal_cnt sat", illegal_cnt, 8'd255);

        // reset while a write is pending
        go(enc_i(3'd0, 5'd9, 5'd0, 12'd99));
        drain(1);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = cyc + 1; i < cyc + 5; i++) expq[i] = '0;
        for (int i = 0; i < 32; i++) begin
            arch[i] = 32'h0;
            lag[i]  = 32'h0;
        end
        #1;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst data", alu_output_data, 32'h0);
        chk("rst out_rd", out_rd, 5'd0);
        chk("rst illegal_cnt", illegal_cnt, 8'd0);
        drain(2);
        @(negedge clk);
        rst_n = 1'b1;
        drain(3);
        dbg(5'd9, 32'h0, "dbg x9 after reset");
        dbg(5'd31, 32'h0, "dbg x31 after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
